// File: rtl/test_transmitter.sv
// Ethernet test-frame generator: header then LENGTH payload beats whose bytes follow a
// free-running beat counter, with optional idle gap between frames and debug counters.
module test_transmitter #(
  parameter int unsigned LENGTH     = 512,
  parameter logic [47:0] LOCAL_MAC  = 48'h02_00_00_00_00_00,
  parameter logic [47:0] DST_MAC    = 48'h02_00_00_00_00_00,
  parameter logic [15:0] ETH_TYPE   = 16'h88B5,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [31:0]           frame_limit,
  output logic                  m_eth_hdr_valid,
  input  logic                  m_eth_hdr_ready,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic                  m_eth_payload_axis_tvalid,
  input  logic                  m_eth_payload_axis_tready,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
  output logic                  busy,
  output logic [31:0]           frame_count,
  output logic [31:0]           beat_count
);

  localparam int unsigned        LenBits  = $clog2(LENGTH);
  localparam logic [LenBits-1:0] LastIdx  = LenBits'(LENGTH - 1);
  localparam int unsigned        GapLastI = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [15:0]        GapLast  = 16'(GapLastI);
  localparam bit                 HasGap   = (GAP_CYCLES > 0);

  typedef enum logic [1:0] {StIdle, StHdr, StPayload, StGap} state_e;

  logic [1:0]  r_rst_sync;
  logic        w_rst_n;
  state_e      r_state, w_state_next;
  logic [31:0] r_frame_count, r_beat_count, w_fc_inc;
  logic [15:0] r_gap_cnt, w_gap_cnt_next;
  logic        w_hdr_hs, w_beat_hs, w_last, w_frame_done, w_start_now, w_start_after;

  // Assertion is immediate; release is delayed two clocks to avoid metastable exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_hdr_hs      = (r_state == StHdr) && m_eth_hdr_ready;
  assign w_beat_hs     = (r_state == StPayload) && m_eth_payload_axis_tready;
  assign w_last        = (r_beat_count[LenBits-1:0] == LastIdx);
  assign w_frame_done  = w_beat_hs && w_last;
  assign w_fc_inc      = r_frame_count + 32'd1;
  assign w_start_now   = enable && ((frame_limit == 32'd0) || (r_frame_count < frame_limit));
  // Decision at the tlast handshake must see the frame that is just completing.
  assign w_start_after = enable && ((frame_limit == 32'd0) || (w_fc_inc < frame_limit));

  always_comb begin
    w_state_next   = r_state;
    w_gap_cnt_next = r_gap_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_start_now) w_state_next = StHdr;
      end
      StHdr: begin
        if (w_hdr_hs) w_state_next = StPayload;
      end
      StPayload: begin
        if (w_frame_done) begin
          if (HasGap) begin
            w_state_next   = StGap;
            w_gap_cnt_next = 16'd0;
          end else begin
            w_state_next = w_start_after ? StHdr : StIdle;
          end
        end
      end
      StGap: begin
        if (r_gap_cnt == GapLast) w_state_next = w_start_now ? StHdr : StIdle;
        else                      w_gap_cnt_next = r_gap_cnt + 16'd1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= StIdle;
      r_gap_cnt     <= 16'd0;
      r_frame_count <= 32'd0;
      r_beat_count  <= 32'd0;
    end else begin
      r_state   <= w_state_next;
      r_gap_cnt <= w_gap_cnt_next;
      if (w_beat_hs)    r_beat_count  <= r_beat_count + 32'd1;
      if (w_frame_done) r_frame_count <= w_fc_inc;
    end
  end

  // All handshake outputs derive from registers only, so they hold while stalled.
  assign m_eth_hdr_valid           = (r_state == StHdr);
  assign m_eth_payload_axis_tvalid = (r_state == StPayload);
  assign m_eth_payload_axis_tlast  = (r_state == StPayload) && w_last;
  assign m_eth_payload_axis_tdata  = r_beat_count[DATA_WIDTH-1:0];
  assign m_eth_payload_axis_tuser  = 1'b0;
  assign m_eth_dest_mac            = DST_MAC;
  assign m_eth_src_mac             = LOCAL_MAC;
  assign m_eth_type                = ETH_TYPE;
  assign busy                      = (r_state != StIdle);
  assign frame_count               = r_frame_count;
  assign beat_count                = r_beat_count;

endmodule
